uart_rx: RTL and testbench

UART receiver; the companion to the team's uart_tx.
- Frame format: 8 data bits LSB first, one start bit, one stop bit, no parity.
- Oversamples rxPin with the system clock and samples each bit at its midpoint.
- Holds the received byte in an output register, with a ready/read handshake toward the host logic (CPU bus or FIFO).

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, 2-flop input synchronizer, mid-bit sampling with a ready/read
// handshake. A frame that ends with a low stop bit parks in BREAK until the line idles high again.
module uart_rx #(
  parameter int BAUD  = 115_200,
  parameter int CLOCK = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxPin,
  input  logic       rdEn,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       busy,
  output logic       frameErr,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLOCK / BAUD;
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int WIDTH        = $clog2(CLKS_PER_BIT);

  localparam logic [WIDTH-1:0] HALF_CNT = WIDTH'(HALF_BIT);
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // Synchronizer resets to the idle-high line level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxPin;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;

    if (rdEn && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // A read landing on the completion edge wins over the overrun.
            dout_d  = shift_q;
            rdy_d   = 1'b1;
            if (rdy_q && !rdEn) ovr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dout     = dout_q;
  assign rdy      = rdy_q;
  assign busy     = (state_q != IDLE);
  assign frameErr = ferr_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: vector table, directed corner cases, random frames vs a byte-level model.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  // Pin falls after edge k: 2 sync edges + 1 IDLE edge + HALF_BIT + 9*CPB + 1.
  localparam int DONE_TICK = 3 + 7 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxPin = 1'b1;
  logic       rdEn = 1'b0;
  logic [7:0] dout;
  logic       rdy, busy, frameErr, overrun;

  uart_rx #(.BAUD(1), .CLOCK(16)) dut (
    .clk(clk), .rst(rst), .rxPin(rxPin), .rdEn(rdEn),
    .dout(dout), .rdy(rdy), .busy(busy), .frameErr(frameErr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int   rdy_rise = 0, rise_busy_fall = 0, busy_rise = 0, ferr_cnt = 0;
  logic rdy_p = 1'b0, busy_p = 1'b0;

  always @(negedge clk) begin
    if (rdy && !rdy_p) begin
      rdy_rise++;
      if (busy_p && !busy) rise_busy_fall++;
    end
    if (busy && !busy_p) busy_rise++;
    if (frameErr) ferr_cnt++;
    rdy_p  = rdy;
    busy_p = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxPin = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives nticks of an ideal frame; rdEn is high for the single tick numbered rd_at.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int rd_at, input int nticks);
    for (int i = 0; i < nticks; i++) begin
      int b;
      b = i / CPB;
      if (b == 0)      rxPin = 1'b0;
      else if (b <= 8) rxPin = d[b-1];
      else             rxPin = stop;
      rdEn = (i == rd_at);
      tick();
    end
    rdEn = 1'b0;
  endtask

  task automatic read_pulse();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         rd_next;
    logic [7:0] exp_dout;
    bit         exp_rdy;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         r0, b0, f0;
    bit         prev_rd;
    logic [7:0] exp_dout;
    bit         exp_rdy, exp_ovr;
    int         exp_ferr;

    vecs[0] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[3] = '{8'h22, 1'b0, 8'h22, 1'b1, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

    #2 rst = 1'b0;
    #1;
    check("reset dout", dout, 8'h00);
    check("reset rdy", rdy, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset frameErr", frameErr, 1'b0);
    check("reset overrun", overrun, 1'b0);
    tick(); tick();
    rst = 1'b1;
    idle(4);

    // Single clean frame
    r0 = rdy_rise; b0 = rise_busy_fall; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, -1, FRAME);
    check("t1 dout", dout, 8'hA5);
    check("t1 rdy", rdy, 1'b1);
    check("t1 rdy rises once", rdy_rise - r0, 1);
    check("t1 busy falls with rdy", rise_busy_fall - b0, 1);
    check("t1 no frameErr", ferr_cnt - f0, 0);
    check("t1 busy idle", busy, 1'b0);
    read_pulse();
    check("t1 rdy after read", rdy, 1'b0);

    // Back-to-back frames; each read lands on the first tick of the following frame
    prev_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, 1'b1, prev_rd ? 0 : -1, FRAME);
      check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d rdy", i), rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d overrun", i), overrun, vecs[i].exp_ovr);
      prev_rd = vecs[i].rd_next;
    end
    read_pulse();
    check("vec tail rdy", rdy, 1'b0);
    check("vec tail overrun", overrun, 1'b0);
    idle(4);

    // Short low glitch is rejected at the start-bit midpoint
    r0 = busy_rise; f0 = ferr_cnt;
    rxPin = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    idle(24);
    check("t3 busy pulsed", busy_rise - r0, 1);
    check("t3 busy back to 0", busy, 1'b0);
    check("t3 rdy", rdy, 1'b0);
    check("t3 frameErr", ferr_cnt - f0, 0);

    // Low stop bit, then the line held low
    f0 = ferr_cnt; r0 = rdy_rise;
    send_frame(8'h55, 1'b0, -1, FRAME);
    for (int i = 0; i < 40; i++) tick();
    check("t4 one frameErr", ferr_cnt - f0, 1);
    check("t4 rdy", rdy, 1'b0);
    check("t4 busy in break", busy, 1'b1);
    idle(4);
    check("t4 busy released", busy, 1'b0);
    send_frame(8'h81, 1'b1, -1, FRAME);
    check("t4 recover dout", dout, 8'h81);
    check("t4 recover rdy", rdy, 1'b1);
    check("t4 no extra frames", rdy_rise - r0, 1);
    read_pulse();

    // Overrun, read timing, and read on the completion edge
    send_frame(8'h11, 1'b1, -1, FRAME);
    send_frame(8'h22, 1'b1, -1, FRAME);
    check("t5 dout", dout, 8'h22);
    check("t5 rdy", rdy, 1'b1);
    check("t5 overrun", overrun, 1'b1);
    rdEn = 1'b1;
    #1;
    check("t5 rdy before edge", rdy, 1'b1);
    tick();
    rdEn = 1'b0;
    check("t5 rdy after read", rdy, 1'b0);
    check("t5 overrun after read", overrun, 1'b0);
    send_frame(8'h11, 1'b1, -1, FRAME);
    send_frame(8'h22, 1'b1, DONE_TICK - 1, FRAME);
    check("t5 simul dout", dout, 8'h22);
    check("t5 simul rdy", rdy, 1'b1);
    check("t5 simul overrun", overrun, 1'b0);
    send_frame(8'h44, 1'b1, -1, FRAME);
    check("t5 overrun set again", overrun, 1'b1);
    send_frame(8'h33, 1'b1, DONE_TICK - 1, FRAME);
    check("t5 simul clears dout", dout, 8'h33);
    check("t5 simul clears rdy", rdy, 1'b1);
    check("t5 simul clears overrun", overrun, 1'b0);
    read_pulse();

    // Random frames against a byte-level model
    exp_dout = dout; exp_rdy = 1'b0; exp_ovr = 1'b0; exp_ferr = ferr_cnt;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit         bad;
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      idle($urandom_range(0, 20));
      send_frame(d, !bad, -1, FRAME);
      if (bad) begin
        for (int i = 0; i < int'($urandom_range(0, 30)); i++) tick();
        idle(4);
        exp_ferr++;
      end else begin
        if (exp_rdy) exp_ovr = 1'b1;
        exp_rdy  = 1'b1;
        exp_dout = d;
      end
      check($sformatf("rnd%0d dout", n), dout, exp_dout);
      check($sformatf("rnd%0d rdy", n), rdy, exp_rdy);
      check($sformatf("rnd%0d overrun", n), overrun, exp_ovr);
      check($sformatf("rnd%0d frameErr count", n), ferr_cnt, exp_ferr);
      if ($urandom_range(0, 1) == 1) begin
        read_pulse();
        if (exp_rdy) begin
          exp_rdy = 1'b0;
          exp_ovr = 1'b0;
        end
        check($sformatf("rnd%0d rdy after rdEn", n), rdy, exp_rdy);
        check($sformatf("rnd%0d overrun after rdEn", n), overrun, exp_ovr);
      end
    end
    if (rdy) read_pulse();

    // Asynchronous reset in the middle of data bit 4
    send_frame(8'h11, 1'b1, -1, FRAME);
    send_frame(8'h22, 1'b1, -1, FRAME);
    check("t6 pre overrun", overrun, 1'b1);
    send_frame(8'hF0, 1'b1, -1, 5 * CPB + 8);
    rst = 1'b0;
    #1;
    check("t6 async dout", dout, 8'h00);
    check("t6 async rdy", rdy, 1'b0);
    check("t6 async busy", busy, 1'b0);
    check("t6 async overrun", overrun, 1'b0);
    rxPin = 1'b1;
    tick(); tick();
    rst = 1'b1;
    f0 = ferr_cnt;
    idle(4);
    send_frame(8'h0F, 1'b1, -1, FRAME);
    check("t6 dout", dout, 8'h0F);
    check("t6 rdy", rdy, 1'b1);
    check("t6 overrun", overrun, 1'b0);
    check("t6 frameErr", ferr_cnt - f0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
